// File: rtl/imm_decode_pkg.sv
// Shared types and opcode constants for the immediate-decode stage.
// fmt_t codes are visible on the stage outputs; count_t is the skid-FIFO occupancy.
package imm_decode_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_t;

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_FULL  = 2'd2
  } count_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

endpackage

// File: rtl/imm_decode_stage_imm_extract.sv
// Combinational format classifier and immediate generator for one RV instruction.
// Immediates are built as 32-bit signed values, then sign-extended to XLEN.
module imm_extract
  import imm_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output fmt_t            fmt,
  output logic            illegal
);

  localparam bit IS64 = (XLEN == 64);

  logic [6:0]         opcode;
  logic signed [31:0] imm32;

  always_comb begin
    opcode  = instr[6:0];
    imm32   = '0;
    fmt     = FMT_ILL;
    illegal = 1'b1;
    if (instr[1:0] == 2'b11) begin
      case (opcode)
        OP_LOAD, OP_IMM, OP_JALR: begin
          imm32   = {{20{instr[31]}}, instr[31:20]};
          fmt     = FMT_I;
          illegal = 1'b0;
        end
        OP_IMM32: begin
          if (IS64) begin
            imm32   = {{20{instr[31]}}, instr[31:20]};
            fmt     = FMT_I;
            illegal = 1'b0;
          end
        end
        OP_STORE: begin
          imm32   = {{20{instr[31]}}, instr[31:25], instr[11:7]};
          fmt     = FMT_S;
          illegal = 1'b0;
        end
        OP_BRANCH: begin
          imm32   = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
          fmt     = FMT_B;
          illegal = 1'b0;
        end
        OP_LUI, OP_AUIPC: begin
          imm32   = {instr[31:12], 12'b0};
          fmt     = FMT_U;
          illegal = 1'b0;
        end
        OP_JAL: begin
          imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
          fmt     = FMT_J;
          illegal = 1'b0;
        end
        OP_REG: begin
          fmt     = FMT_R;
          illegal = 1'b0;
        end
        OP_REG32: begin
          if (IS64) begin
            fmt     = FMT_R;
            illegal = 1'b0;
          end
        end
        default: ;
      endcase
    end
    // signed cast makes the width change a sign extension (bit 31 for U on RV64)
    imm = XLEN'(imm32);
  end

endmodule

// File: rtl/imm_decode_stage.sv
// Registered immediate-decode stage: decode on accept, then a 2-entry skid FIFO
// whose head register drives the outputs directly.
module imm_decode_stage
  import imm_decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output fmt_t            out_fmt,
  output logic            out_illegal
);

  logic [XLEN-1:0] dec_imm;
  fmt_t            dec_fmt;
  logic            dec_illegal;

  count_t          count_reg, count_next;
  logic [XLEN-1:0] head_imm_reg, head_imm_next, tail_imm_reg, tail_imm_next;
  fmt_t            head_fmt_reg, head_fmt_next, tail_fmt_reg, tail_fmt_next;
  logic            head_ill_reg, head_ill_next, tail_ill_reg, tail_ill_next;
  logic            push, pop;

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr   (in_instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // in_ready depends on state only, so no comb path from out_ready
  assign in_ready    = (count_reg != CNT_FULL);
  assign out_valid   = (count_reg != CNT_EMPTY);
  assign out_imm     = head_imm_reg;
  assign out_fmt     = head_fmt_reg;
  assign out_illegal = head_ill_reg;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready;

  always_comb begin
    count_next    = count_reg;
    head_imm_next = head_imm_reg;
    head_fmt_next = head_fmt_reg;
    head_ill_next = head_ill_reg;
    tail_imm_next = tail_imm_reg;
    tail_fmt_next = tail_fmt_reg;
    tail_ill_next = tail_ill_reg;
    if (flush) begin
      count_next = CNT_EMPTY;
    end else begin
      case (count_reg)
        CNT_EMPTY: begin
          if (push) begin
            head_imm_next = dec_imm;
            head_fmt_next = dec_fmt;
            head_ill_next = dec_illegal;
            count_next    = CNT_ONE;
          end
        end
        CNT_ONE: begin
          if (push && pop) begin
            head_imm_next = dec_imm;
            head_fmt_next = dec_fmt;
            head_ill_next = dec_illegal;
          end else if (push) begin
            tail_imm_next = dec_imm;
            tail_fmt_next = dec_fmt;
            tail_ill_next = dec_illegal;
            count_next    = CNT_FULL;
          end else if (pop) begin
            count_next = CNT_EMPTY;
          end
        end
        CNT_FULL: begin
          if (pop) begin
            head_imm_next = tail_imm_reg;
            head_fmt_next = tail_fmt_reg;
            head_ill_next = tail_ill_reg;
            count_next    = CNT_ONE;
          end
        end
        default: count_next = CNT_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg    <= CNT_EMPTY;
      head_imm_reg <= '0;
      head_fmt_reg <= FMT_R;
      head_ill_reg <= 1'b0;
      tail_imm_reg <= '0;
      tail_fmt_reg <= FMT_R;
      tail_ill_reg <= 1'b0;
    end else begin
      count_reg    <= count_next;
      head_imm_reg <= head_imm_next;
      head_fmt_reg <= head_fmt_next;
      head_ill_reg <= head_ill_next;
      tail_imm_reg <= tail_imm_next;
      tail_fmt_reg <= tail_fmt_next;
      tail_ill_reg <= tail_ill_next;
    end
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// Directed bench for imm_decode_stage: XLEN=32 and XLEN=64 instances share stimulus.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_imm_decode_stage;
  import imm_decode_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [31:0] in_instr;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] imm32;
  fmt_t        fmt32;
  logic        in_ready64, out_valid64, ill64;
  logic [63:0] imm64;
  fmt_t        fmt64;

  int tests_run = 0;
  int tests_failed = 0;

  imm_decode_stage #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_illegal(ill32)
  );

  imm_decode_stage #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_illegal(ill64)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = 32'h0;
    step; step;
    tests_run++; if (out_valid32 !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", out_valid32); end
    tests_run++; if (imm32 !== 32'h0) begin tests_failed++; $display("FAIL reset_imm got %h want 0", imm32); end
    tests_run++; if (fmt32 !== FMT_R) begin tests_failed++; $display("FAIL reset_fmt got %0d want 0", fmt32); end
    tests_run++; if (ill32 !== 1'b0) begin tests_failed++; $display("FAIL reset_illegal got %b want 0", ill32); end
    reset = 1'b0;
    step;
    tests_run++; if (in_ready32 !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready32); end
    tests_run++; if (out_valid64 !== 1'b0) begin tests_failed++; $display("FAIL reset_valid64 got %b want 0", out_valid64); end
  endtask

  task automatic test_formats;
    logic [31:0] iv  [11];
    logic [31:0] e32 [11];
    fmt_t        f32 [11];
    logic [63:0] e64 [11];
    fmt_t        f64 [11];
    iv  = '{32'h00002083, 32'hFFF00093, 32'hFE20AC23, 32'hFE000EE3, 32'h123450B7, 32'h0080006F,
            32'h002081B3, 32'h800000B7, 32'h0010809B, 32'h00000000, 32'hFFFFFFFF};
    e32 = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFF8, 32'hFFFFFFFC, 32'h12345000, 32'h8,
            32'h0, 32'h80000000, 32'h0, 32'h0, 32'h0};
    f32 = '{FMT_I, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R, FMT_U, FMT_ILL, FMT_ILL, FMT_ILL};
    e64 = '{64'h0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFF8, 64'hFFFFFFFFFFFFFFFC,
            64'h0000000012345000, 64'h8, 64'h0, 64'hFFFFFFFF80000000, 64'h1, 64'h0, 64'h0};
    f64 = '{FMT_I, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R, FMT_U, FMT_I, FMT_ILL, FMT_ILL};
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1; in_instr = iv[i];
      step;
      $display("[TB] fmt instr=%h imm32=%h fmt32=%0d imm64=%h fmt64=%0d", iv[i], imm32, fmt32, imm64, fmt64);
      tests_run++; if (out_valid32 !== 1'b1) begin tests_failed++; $display("FAIL fmt_valid32[%0d] got %b want 1", i, out_valid32); end
      tests_run++; if (imm32 !== e32[i]) begin tests_failed++; $display("FAIL fmt_imm32[%0d] got %h want %h", i, imm32, e32[i]); end
      tests_run++; if (fmt32 !== f32[i]) begin tests_failed++; $display("FAIL fmt_fmt32[%0d] got %0d want %0d", i, fmt32, f32[i]); end
      tests_run++; if (ill32 !== (f32[i] == FMT_ILL)) begin tests_failed++; $display("FAIL fmt_ill32[%0d] got %b want %b", i, ill32, f32[i] == FMT_ILL); end
      tests_run++; if (out_valid64 !== 1'b1) begin tests_failed++; $display("FAIL fmt_valid64[%0d] got %b want 1", i, out_valid64); end
      tests_run++; if (imm64 !== e64[i]) begin tests_failed++; $display("FAIL fmt_imm64[%0d] got %h want %h", i, imm64, e64[i]); end
      tests_run++; if (fmt64 !== f64[i]) begin tests_failed++; $display("FAIL fmt_fmt64[%0d] got %0d want %0d", i, fmt64, f64[i]); end
      tests_run++; if (ill64 !== (f64[i] == FMT_ILL)) begin tests_failed++; $display("FAIL fmt_ill64[%0d] got %b want %b", i, ill64, f64[i] == FMT_ILL); end
    end
    in_valid = 1'b0;
    step;
    tests_run++; if (out_valid32 !== 1'b0) begin tests_failed++; $display("FAIL fmt_drain got %b want 0", out_valid32); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093;
    step;
    $display("[TB] bp push A in_ready=%b head=%h", in_ready32, imm32);
    tests_run++; if (in_ready32 !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_one got %b want 1", in_ready32); end
    in_instr = 32'h00200093;
    step;
    $display("[TB] bp push B in_ready=%b head=%h", in_ready32, imm32);
    tests_run++; if (in_ready32 !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_full got %b want 0", in_ready32); end
    in_instr = 32'h00300093;
    step;
    $display("[TB] bp hold C in_ready=%b head=%h", in_ready32, imm32);
    tests_run++; if (in_ready32 !== 1'b0) begin tests_failed++; $display("FAIL bp_ready_hold got %b want 0", in_ready32); end
    tests_run++; if (imm32 !== 32'd1) begin tests_failed++; $display("FAIL bp_head_stable got %h want 1", imm32); end
    out_ready = 1'b1;
    step;
    $display("[TB] bp pop A head=%h", imm32);
    tests_run++; if (imm32 !== 32'd2 || out_valid32 !== 1'b1) begin tests_failed++; $display("FAIL bp_second got %h/%b want 2/1", imm32, out_valid32); end
    tests_run++; if (in_ready32 !== 1'b1) begin tests_failed++; $display("FAIL bp_ready_after got %b want 1", in_ready32); end
    step;
    $display("[TB] bp pop B head=%h", imm32);
    tests_run++; if (imm32 !== 32'd3 || out_valid32 !== 1'b1) begin tests_failed++; $display("FAIL bp_third got %h/%b want 3/1", imm32, out_valid32); end
    in_valid = 1'b0;
    step;
    tests_run++; if (out_valid32 !== 1'b0) begin tests_failed++; $display("FAIL bp_drain got %b want 0", out_valid32); end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093;
    step;
    in_instr = 32'h00200093;
    step;
    tests_run++; if (in_ready32 !== 1'b0) begin tests_failed++; $display("FAIL flush_full got %b want 0", in_ready32); end
    flush = 1'b1; in_instr = 32'h00500093; out_ready = 1'b1;
    step;
    $display("[TB] flush full valid=%b in_ready=%b", out_valid32, in_ready32);
    tests_run++; if (out_valid32 !== 1'b0) begin tests_failed++; $display("FAIL flush_full_valid got %b want 0", out_valid32); end
    tests_run++; if (in_ready32 !== 1'b1) begin tests_failed++; $display("FAIL flush_full_ready got %b want 1", in_ready32); end
    flush = 1'b0; in_valid = 1'b0;
    step;
    tests_run++; if (out_valid32 !== 1'b0) begin tests_failed++; $display("FAIL flush_no_ghost got %b want 0", out_valid32); end
    in_valid = 1'b1; in_instr = 32'h00100093;
    step;
    flush = 1'b1; in_instr = 32'h00500093;
    step;
    $display("[TB] flush one valid=%b", out_valid32);
    tests_run++; if (out_valid32 !== 1'b0) begin tests_failed++; $display("FAIL flush_one_valid got %b want 0", out_valid32); end
    flush = 1'b0; in_instr = 32'h00600093;
    step;
    tests_run++; if (out_valid32 !== 1'b1 || imm32 !== 32'd6) begin tests_failed++; $display("FAIL flush_next got %b/%h want 1/6", out_valid32, imm32); end
    in_valid = 1'b0;
    step;
    tests_run++; if (out_valid32 !== 1'b0) begin tests_failed++; $display("FAIL flush_drain got %b want 0", out_valid32); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] w;
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = {12'd9, 20'h00093};
    step;
    for (int i = 0; i < 10; i++) begin
      w = {12'(i + 10), 20'h00093};
      in_instr = w;
      step;
      $display("[TB] b2b instr=%h head=%h valid=%b", w, imm32, out_valid32);
      tests_run++; if (out_valid32 !== 1'b1 || in_ready32 !== 1'b1) begin tests_failed++; $display("FAIL b2b_state[%0d] got %b/%b want 1/1", i, out_valid32, in_ready32); end
      tests_run++; if (imm32 !== 32'(i + 10)) begin tests_failed++; $display("FAIL b2b_imm[%0d] got %h want %h", i, imm32, 32'(i + 10)); end
    end
    in_valid = 1'b0;
    step;
    tests_run++; if (out_valid32 !== 1'b0) begin tests_failed++; $display("FAIL b2b_drain got %b want 0", out_valid32); end
  endtask

  task automatic test_reset_midstream;
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFE000EE3;
    step; step;
    in_valid = 1'b0;
    tests_run++; if (out_valid32 !== 1'b1 || imm32 !== 32'hFFFFFFFC || in_ready32 !== 1'b0) begin tests_failed++; $display("FAIL mid_full got %b/%h/%b want 1/fffffffc/0", out_valid32, imm32, in_ready32); end
    reset = 1'b1;
    #1;
    $display("[TB] mid reset valid=%b imm=%h fmt=%0d", out_valid32, imm32, fmt32);
    tests_run++; if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin tests_failed++; $display("FAIL mid_valid got %b/%b want 0/0", out_valid32, out_valid64); end
    tests_run++; if (imm32 !== 32'h0 || imm64 !== 64'h0) begin tests_failed++; $display("FAIL mid_imm got %h/%h want 0", imm32, imm64); end
    tests_run++; if (fmt32 !== FMT_R || fmt64 !== FMT_R) begin tests_failed++; $display("FAIL mid_fmt got %0d/%0d want 0", fmt32, fmt64); end
    #2;
    reset = 1'b0;
    step;
    tests_run++; if (in_ready32 !== 1'b1 || out_valid32 !== 1'b0) begin tests_failed++; $display("FAIL mid_release got %b/%b want 1/0", in_ready32, out_valid32); end
  endtask

  initial begin
    test_reset;
    test_formats;
    test_backpressure;
    test_flush;
    test_back_to_back;
    test_reset_midstream;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
